c1126_out_packer: RTL



---
 rtl/c1126_pkg.sv | 18 +
 rtl/c1126_out_packer_if.sv | 22 ++
 rtl/c1126_byte_fifo.sv | 62 ++++++
 rtl/c1126_out_packer.sv | 100 ++++++++++
 4 files changed

// File: rtl/c1126_pkg.sv
// Shared widths and packer state encoding for the c1126 output packer slice.
package c1126_pkg;

   localparam int NIB_W  = 4;
   localparam int BYTE_W = 8;

   typedef enum logic {
      PK_EMPTY = 1'b0,
      PK_HALF  = 1'b1
   } pack_state_t;

   // The first nibble of a pair always lands in the low half of the byte.
   function automatic logic [BYTE_W-1:0] pack_byte(input logic [NIB_W-1:0] hi,
                                                   input logic [NIB_W-1:0] lo);
      return {hi, lo};
   endfunction

endpackage

// File: rtl/c1126_out_packer_if.sv
// Nibble input and byte valid/ready output bundle of the c1126 output packer.
interface c1126_out_packer_if;
   import c1126_pkg::*;

   logic [NIB_W-1:0]  o_in;
   logic              o_vld;
   logic              flush;
   logic [BYTE_W-1:0] byte_out;
   logic              byte_vld;
   logic              byte_rdy;

   modport master (
      output o_in, o_vld, flush, byte_rdy,
      input  byte_out, byte_vld
   );

   modport slave (
      input  o_in, o_vld, flush, byte_rdy,
      output byte_out, byte_vld
   );

endinterface

// File: rtl/c1126_byte_fifo.sv
// First-word-fall-through byte FIFO; occupancy is counted separately from the pointers.
module c1126_byte_fifo
   import c1126_pkg::*;
#(
   parameter int DEPTH = 4
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic [BYTE_W-1:0]       din,
   input  logic                    pop,
   output logic [BYTE_W-1:0]       dout,
   output logic [$clog2(DEPTH):0]  fill,
   output logic                    full,
   output logic                    empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [BYTE_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr_reg;
   logic [AW-1:0]     rd_ptr_reg;
   logic [AW:0]       fill_reg;
   logic              do_push;
   logic              do_pop;

   assign empty = (fill_reg == '0);
   assign full  = (fill_reg == FULL_CNT);
   assign fill  = fill_reg;

   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   assign dout = empty ? '0 : mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr_reg] <= din;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         fill_reg   <= '0;
      end else begin
         if (do_push)
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (do_pop)
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         case ({do_push, do_pop})
            2'b10:   fill_reg <= fill_reg + (AW+1)'(1);
            2'b01:   fill_reg <= fill_reg - (AW+1)'(1);
            default: fill_reg <= fill_reg;
         endcase
      end
   end

endmodule

// File: rtl/c1126_out_packer.sv
// Packs qualified c1126 output nibbles into bytes, queues them, and counts pattern changes.
module c1126_out_packer
   import c1126_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
)
(
   input  logic                    clk,
   input  logic                    rst,
   c1126_out_packer_if.slave       bus,
   output logic                    ovf,
   output logic [$clog2(DEPTH):0]  fill,
   output logic [CNT_W-1:0]        chg_cnt
);

   pack_state_t       state_reg, state_next;
   logic [NIB_W-1:0]  lo_reg, lo_next;
   logic [NIB_W-1:0]  last_reg;
   logic              ovf_reg;
   logic [CNT_W-1:0]  chg_cnt_reg;
   logic              push;
   logic [BYTE_W-1:0] push_data;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;

   always_comb begin
      state_next = state_reg;
      lo_next    = lo_reg;
      push       = 1'b0;
      push_data  = '0;
      case (state_reg)
         PK_EMPTY: begin
            if (bus.o_vld && bus.flush) begin
               push      = 1'b1;
               push_data = pack_byte('0, bus.o_in);
            end else if (bus.o_vld) begin
               lo_next    = bus.o_in;
               state_next = PK_HALF;
            end
         end
         PK_HALF: begin
            // A new nibble completes the pair even when flush is also high.
            if (bus.o_vld) begin
               push       = 1'b1;
               push_data  = pack_byte(bus.o_in, lo_reg);
               state_next = PK_EMPTY;
            end else if (bus.flush) begin
               push       = 1'b1;
               push_data  = pack_byte('0, lo_reg);
               state_next = PK_EMPTY;
            end
         end
         default: state_next = PK_EMPTY;
      endcase
   end

   assign pop = ~fifo_empty & bus.byte_rdy;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= PK_EMPTY;
         lo_reg      <= '0;
         last_reg    <= '0;
         ovf_reg     <= 1'b0;
         chg_cnt_reg <= '0;
      end else begin
         state_reg <= state_next;
         lo_reg    <= lo_next;
         // Dropped bytes still advance the packer; only the sticky flag records them.
         if (push && fifo_full && !pop)
            ovf_reg <= 1'b1;
         if (bus.o_vld) begin
            last_reg <= bus.o_in;
            if (bus.o_in != last_reg && chg_cnt_reg != '1)
               chg_cnt_reg <= chg_cnt_reg + CNT_W'(1);
         end
      end
   end

   c1126_byte_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (push_data),
      .pop   (pop),
      .dout  (bus.byte_out),
      .fill  (fill),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign bus.byte_vld = ~fifo_empty;
   assign ovf          = ovf_reg;
   assign chg_cnt      = chg_cnt_reg;

endmodule
